// File: rtl/therm2bin_pipe.sv
// therm2bin_pipe: pipelined thermometer-to-binary encoder for the flash-ADC back end.
// Three register stages: input capture, bubble correction plus per-group partial
// popcounts, then the final sum with the full-scale and bubble flags. A saturating
// counter tracks how many output samples needed bubble correction.
module therm2bin_pipe #(
   parameter int LOG2N = 6,   // thermometer width N = 2**LOG2N
   parameter int GROUP = 16,  // partial-popcount group size (power of 2, divides N)
   parameter int CNT_W = 16   // bubble event counter width
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [2**LOG2N-1:0] therm_in,
   input  logic                clr_cnt,
   output logic                out_valid,
   output logic [LOG2N:0]      code,
   output logic                bubble,
   output logic                full,
   output logic [CNT_W-1:0]    bubble_cnt
);

   localparam int N  = 2**LOG2N;          // comparator count
   localparam int NG = N / GROUP;         // number of partial-popcount groups
   localparam int GW = $clog2(GROUP) + 1; // width of one group count (0..GROUP)
   localparam int CW = LOG2N + 1;         // width of the final code (0..N)

   // ------------------------------------------------------------------
   // Stage 1: capture the raw comparator word
   // ------------------------------------------------------------------
   logic [N-1:0] t;
   logic         v1;

   // Register the thermometer word and its valid bit.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its sources regardless of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t  <= '0;
         v1 <= 1'b0;
      end else begin
         t  <= therm_in;
         v1 <= in_valid;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: majority bubble correction and partial popcounts
   // ------------------------------------------------------------------
   // The word is padded with an implied 1 below bit 0 and an implied 0
   // above bit N-1, so the ends behave like a clean thermometer edge.
   logic [N+1:0]  t_ext;
   logic [N-1:0]  c;
   logic [GW-1:0] grp_d [NG];
   logic [GW-1:0] grp_q [NG];
   logic          bub2;
   logic          v2;

   assign t_ext = {1'b0, t, 1'b1};

   // Three-input majority over each bit and its two neighbours.
   // NOTE: combinational outputs get a full default before any loop or branch,
   // so no path through the block can leave a bit unassigned and infer a latch.
   always_comb begin
      c = '0;
      for (int i = 0; i < N; i++) begin
         c[i] = (t_ext[i]   & t_ext[i+1]) |
                (t_ext[i]   & t_ext[i+2]) |
                (t_ext[i+1] & t_ext[i+2]);
      end
   end

   // Count the ones of the corrected word within each group.
   always_comb begin
      grp_d = '{default: '0};
      for (int g = 0; g < NG; g++) begin
         for (int j = 0; j < GROUP; j++) begin
            grp_d[g] = grp_d[g] + GW'(c[g*GROUP + j]);
         end
      end
   end

   // Register the group counts, the bubble flag and the valid bit.
   // NOTE: the group-count array is a pipeline register rather than storage,
   // so it is cleared on reset like every other stage; nothing stale can leak
   // into the first sum after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grp_q <= '{default: '0};
         bub2  <= 1'b0;
         v2    <= 1'b0;
      end else begin
         grp_q <= grp_d;
         bub2  <= (c != t);
         v2    <= v1;
      end
   end

   // ------------------------------------------------------------------
   // Stage 3: final sum and output flags
   // ------------------------------------------------------------------
   logic [CW-1:0] sum;

   // Add the group counts; CW bits always holds the maximum value N.
   always_comb begin
      sum = '0;
      for (int g = 0; g < NG; g++) begin
         sum = sum + CW'(grp_q[g]);
      end
   end

   // Present a new result only for valid samples; otherwise hold the last one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         code      <= '0;
         bubble    <= 1'b0;
         full      <= 1'b0;
      end else begin
         out_valid <= v2;
         if (v2) begin
            code   <= sum;
            bubble <= bub2;
            full   <= (sum == CW'(N));
         end
      end
   end

   // ------------------------------------------------------------------
   // Bubble event counter
   // ------------------------------------------------------------------
   // Count presented samples that needed correction; clear has priority and
   // the count sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_cnt <= '0;
      end else if (clr_cnt) begin
         bubble_cnt <= '0;
      end else if (out_valid && bubble && (bubble_cnt != '1)) begin
         bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_therm2bin_pipe.sv
// Bench for therm2bin_pipe: a 64-input and a 16-input instance are exercised in
// turn with the same directed scenarios. Expected results go into a per-instance
// queue together with the cycle they are due; monitors pop and compare whenever
// an instance presents out_valid.
module tb_therm2bin_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // 64-input instance (LOG2N=6, GROUP=16)
   logic        iv_b, clr_b, ov_b, bub_b, full_b;
   logic [63:0] th_b;
   logic [6:0]  code_b;
   logic [3:0]  cnt_b;

   // 16-input instance (LOG2N=4, GROUP=4)
   logic        iv_s, clr_s, ov_s, bub_s, full_s;
   logic [15:0] th_s;
   logic [4:0]  code_s;
   logic [3:0]  cnt_s;

   therm2bin_pipe #(.LOG2N(6), .GROUP(16), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .in_valid(iv_b), .therm_in(th_b), .clr_cnt(clr_b),
      .out_valid(ov_b), .code(code_b), .bubble(bub_b), .full(full_b),
      .bubble_cnt(cnt_b)
   );

   therm2bin_pipe #(.LOG2N(4), .GROUP(4), .CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .in_valid(iv_s), .therm_in(th_s), .clr_cnt(clr_s),
      .out_valid(ov_s), .code(code_s), .bubble(bub_s), .full(full_s),
      .bubble_cnt(cnt_s)
   );

   typedef struct {
      logic [6:0] code;
      logic       bubble;
      logic       full;
      int         due;
   } exp_t;

   exp_t qb[$];
   exp_t qs[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic string tag(input bit s);
      return s ? "N16" : "N64";
   endfunction

   function automatic int n_of(input bit s);
      return s ? 16 : 64;
   endfunction

   function automatic logic [63:0] dut_cnt(input bit s);
      return s ? 64'(cnt_s) : 64'(cnt_b);
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   // Scoreboard compare for one presented sample.
   task automatic check_out(input bit s, input logic [6:0] code, input logic bub, input logic full);
      exp_t e;
      n_vec++;
      if ((s ? qs.size() : qb.size()) == 0) begin
         n_err++;
         $display("FAIL %s unexpected out_valid: got code=%0d at cycle %0d, want no output",
                  tag(s), code, cyc);
         return;
      end
      e = s ? qs.pop_front() : qb.pop_front();
      if (e.code !== code || e.bubble !== bub || e.full !== full || e.due != cyc) begin
         n_err++;
         $display("FAIL %s sample: got code=%0d bubble=%b full=%b cycle=%0d, want code=%0d bubble=%b full=%b cycle=%0d",
                  tag(s), code, bub, full, cyc, e.code, e.bubble, e.full, e.due);
      end
   endtask

   always @(negedge clk) if (!rst && ov_b) check_out(1'b0, code_b, bub_b, full_b);
   always @(negedge clk) if (!rst && ov_s) check_out(1'b1, {2'b00, code_s}, bub_s, full_s);

   // Present one sample on the next falling edge; it is due three edges later.
   task automatic drive(input bit s, input logic [63:0] v, input logic [6:0] code, input logic bub);
      exp_t e;
      @(negedge clk);
      e.code   = code;
      e.bubble = bub;
      e.full   = (int'(code) == n_of(s));
      e.due    = cyc + 3;
      if (s) begin
         th_s = v[15:0];
         iv_s = 1'b1;
         qs.push_back(e);
      end else begin
         th_b = v;
         iv_b = 1'b1;
         qb.push_back(e);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      iv_b = 1'b0;
      iv_s = 1'b0;
   endtask

   task automatic set_clr(input bit s, input logic val);
      if (s) clr_s = val;
      else   clr_b = val;
   endtask

   // Wait (bounded) for all expected samples, then let the counter settle.
   task automatic drain(input bit s);
      int k = 0;
      while ((s ? qs.size() : qb.size()) != 0 && k < 30) begin
         @(negedge clk);
         k++;
      end
      n_vec++;
      if ((s ? qs.size() : qb.size()) != 0) begin
         n_err++;
         $display("FAIL %s drain timeout: got %0d samples outstanding, want 0",
                  tag(s), s ? qs.size() : qb.size());
         if (s) qs.delete();
         else   qb.delete();
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic run(input bit s);
      logic [63:0] ones;
      ones = '1;

      // Reset with samples in flight: leave a non-zero history first.
      drive(s, 64'h0000_0000_0000_00F7, 7'd8, 1'b1);
      idle();
      drain(s);
      check({tag(s), " cnt before reset"}, dut_cnt(s), 64'd1);
      drive(s, 64'h0000_0000_0000_00FF, 7'd8, 1'b0);
      drive(s, 64'h0000_0000_0000_00FF, 7'd8, 1'b0);
      drive(s, 64'h0000_0000_0000_00FF, 7'd8, 1'b0);
      @(posedge clk);
      #1;
      check({tag(s), " out_valid before reset"}, s ? 64'(ov_s) : 64'(ov_b), 64'd1);
      rst  = 1'b1;
      iv_b = 1'b0;
      iv_s = 1'b0;
      #1;
      check({tag(s), " reset out_valid"}, s ? 64'(ov_s)   : 64'(ov_b),   64'd0);
      check({tag(s), " reset code"},      s ? 64'(code_s) : 64'(code_b), 64'd0);
      check({tag(s), " reset bubble"},    s ? 64'(bub_s)  : 64'(bub_b),  64'd0);
      check({tag(s), " reset full"},      s ? 64'(full_s) : 64'(full_b), 64'd0);
      check({tag(s), " reset cnt"},       dut_cnt(s),                    64'd0);
      if (s) qs.delete();
      else   qb.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      // Single clean code, then the range ends.
      drive(s, 64'h0000_0000_0000_00FF, 7'd8, 1'b0);
      idle();
      drain(s);
      drive(s, ones, 7'(n_of(s)), 1'b0);
      drive(s, 64'h0, 7'd0, 1'b0);
      drive(s, 64'h1, 7'd1, 1'b0);
      idle();
      drain(s);
      check({tag(s), " cnt after clean"}, dut_cnt(s), 64'd0);

      // Isolated bubbles: a hole and a lone one.
      drive(s, 64'h0000_0000_0000_00F7, 7'd8, 1'b1);
      idle();
      drain(s);
      check({tag(s), " cnt after hole"}, dut_cnt(s), 64'd1);
      drive(s, 64'h0000_0000_0000_0020, 7'd0, 1'b1);
      idle();
      drain(s);
      check({tag(s), " cnt after lone one"}, dut_cnt(s), 64'd2);

      // Back-to-back codes 0..7, one-cycle gap, then full scale.
      for (int k = 0; k < 8; k++) begin
         drive(s, (64'd1 << k) - 64'd1, 7'(k), 1'b0);
      end
      idle();
      drive(s, ones, 7'(n_of(s)), 1'b0);
      idle();
      drain(s);

      // Saturation, then clear.
      for (int k = 0; k < 20; k++) begin
         drive(s, 64'h0000_0000_0000_0020, 7'd0, 1'b1);
      end
      idle();
      drain(s);
      check({tag(s), " cnt saturated"}, dut_cnt(s), 64'd15);
      @(negedge clk);
      set_clr(s, 1'b1);
      @(negedge clk);
      set_clr(s, 1'b0);
      check({tag(s), " cnt after clear"}, dut_cnt(s), 64'd0);

      // Clear on the very cycle a bubbled sample is presented: clear wins.
      drive(s, 64'h0000_0000_0000_00F7, 7'd8, 1'b1);
      idle();
      repeat (2) @(negedge clk);
      set_clr(s, 1'b1);
      @(negedge clk);
      set_clr(s, 1'b0);
      check({tag(s), " cnt clear beats increment"}, dut_cnt(s), 64'd0);
      @(negedge clk);
      check({tag(s), " cnt stays cleared"}, dut_cnt(s), 64'd0);
      drain(s);
   endtask

   initial begin
      rst   = 1'b1;
      iv_b  = 1'b0;
      iv_s  = 1'b0;
      clr_b = 1'b0;
      clr_s = 1'b0;
      th_b  = '0;
      th_s  = '0;
      repeat (3) @(negedge clk);
      check("N64 initial out_valid", 64'(ov_b), 64'd0);
      check("N16 initial out_valid", 64'(ov_s), 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      run(1'b0);
      run(1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
